// File: rtl/instr_fetch_unit.sv
// ============================================================================
// Module   : instr_fetch_unit
// Purpose  : Fetch stage owning the PC; registers imem words towards decode over
//            valid/ready, halting on misaligned/out-of-range PCs.
// Options  : FETCH_SKID_EN selects a 2-entry output FIFO instead of one register.
// Revision : 1.0 - initial release
// ============================================================================
`default_nettype none

module instr_fetch_unit #(
    parameter logic [31:0] RESET_PC   = 32'h0000_0000,
    parameter int unsigned IMEM_WORDS = 8,
    parameter logic [31:0] ERR_INSTR  = 32'hDEAD_BEEF
) (
    input  logic        clk,
    input  logic        rst_n,
    output logic [31:0] imem_addr_o,
    input  logic [31:0] imem_data_i,
    input  logic        redirect_valid_i,
    input  logic [31:0] redirect_pc_i,
    output logic        id_valid_o,
    input  logic        id_ready_i,
    output logic [31:0] id_instr_o,
    output logic [31:0] id_pc_o,
    output logic        fault_o,
    output logic [1:0]  fault_cause_o
);

    localparam logic [29:0] IMEM_LIMIT = 30'(IMEM_WORDS);

    typedef enum logic [1:0] {
        ST_BOOT  = 2'd0,
        ST_RUN   = 2'd1,
        ST_FAULT = 2'd2
    } state_e;

    state_e      state_q, state_d;
    logic [31:0] pc_q, pc_d;
    logic        fault_q, fault_d;
    logic [1:0]  cause_q, cause_d;

    logic        w_misaligned, w_out_of_range;
    logic        w_slot_free, w_drained;
    logic        w_issue, w_pop, w_flush;
    logic        w_head_valid;
    logic [31:0] w_head_instr, w_head_pc;

    assign w_misaligned   = (pc_q[1:0] != 2'b00);
    assign w_out_of_range = (pc_q[31:2] >= IMEM_LIMIT);
    assign w_flush        = redirect_valid_i;

`ifdef FETCH_SKID_EN
    logic [31:0] buf_instr_q [2];
    logic [31:0] buf_pc_q    [2];
    logic        rd_ptr_q, wr_ptr_q;
    logic [1:0]  count_q;

    // Issue depends only on occupancy so id_ready never reaches imem_addr.
    assign w_slot_free  = (count_q != 2'd2);
    assign w_pop        = (count_q != 2'd0) && id_ready_i;
    assign w_drained    = (count_q == 2'd0) || ((count_q == 2'd1) && id_ready_i);
    assign w_head_valid = (count_q != 2'd0);
    assign w_head_instr = buf_instr_q[rd_ptr_q];
    assign w_head_pc    = buf_pc_q[rd_ptr_q];

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            buf_instr_q[0] <= '0;
            buf_instr_q[1] <= '0;
            buf_pc_q[0]    <= '0;
            buf_pc_q[1]    <= '0;
            rd_ptr_q       <= 1'b0;
            wr_ptr_q       <= 1'b0;
            count_q        <= 2'd0;
        end else if (w_flush) begin
            rd_ptr_q <= wr_ptr_q;
            count_q  <= 2'd0;
        end else begin
            if (w_issue) begin
                buf_instr_q[wr_ptr_q] <= imem_data_i;
                buf_pc_q[wr_ptr_q]    <= pc_q;
                wr_ptr_q              <= ~wr_ptr_q;
            end
            if (w_pop) begin
                rd_ptr_q <= ~rd_ptr_q;
            end
            count_q <= count_q + 2'(w_issue) - 2'(w_pop);
        end
    end
`else
    logic        valid_q;
    logic [31:0] instr_q, ipc_q;

    assign w_slot_free  = !valid_q || id_ready_i;
    assign w_pop        = valid_q && id_ready_i;
    assign w_drained    = w_slot_free;
    assign w_head_valid = valid_q;
    assign w_head_instr = instr_q;
    assign w_head_pc    = ipc_q;

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            valid_q <= 1'b0;
            instr_q <= '0;
            ipc_q   <= '0;
        end else if (w_flush) begin
            valid_q <= 1'b0;
        end else if (w_issue) begin
            valid_q <= 1'b1;
            instr_q <= imem_data_i;
            ipc_q   <= pc_q;
        end else if (w_pop) begin
            valid_q <= 1'b0;
        end
    end
`endif

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state_q <= ST_BOOT;
            pc_q    <= RESET_PC;
            fault_q <= 1'b0;
            cause_q <= 2'b00;
        end else begin
            state_q <= state_d;
            pc_q    <= pc_d;
            fault_q <= fault_d;
            cause_q <= cause_d;
        end
    end

    always_comb begin
        state_d = state_q;
        pc_d    = pc_q;
        fault_d = fault_q;
        cause_d = cause_q;
        w_issue = 1'b0;
        if (redirect_valid_i) begin
            state_d = ST_RUN;
            pc_d    = redirect_pc_i;
            fault_d = 1'b0;
            cause_d = 2'b00;
        end else begin
            case (state_q)
                ST_BOOT: state_d = ST_RUN;
                ST_RUN: begin
                    if (w_misaligned || w_out_of_range) begin
                        // Bad PC is held; fault only once buffered entries are consumed.
                        if (w_drained) begin
                            state_d = ST_FAULT;
                            fault_d = 1'b1;
                            cause_d = w_misaligned ? 2'b01 : 2'b10;
                        end
                    end else if (w_slot_free) begin
                        w_issue = 1'b1;
                        pc_d    = pc_q + 32'd4;
                    end
                end
                ST_FAULT: state_d = ST_FAULT;
                default:  state_d = ST_BOOT;
            endcase
        end
    end

    assign imem_addr_o   = pc_q;
    assign id_valid_o    = w_head_valid;
    assign id_instr_o    = (state_q == ST_FAULT) ? ERR_INSTR : w_head_instr;
    assign id_pc_o       = w_head_pc;
    assign fault_o       = fault_q;
    assign fault_cause_o = cause_q;

endmodule

`default_nettype wire
